// File: rtl/fft_pkg.sv
// fft_pkg: shared types for the FFT output reorder path.
// Complex sample bundle, bank-state enum, bit-reverse helper.
package fft_pkg;

  localparam int FFT_DW = 16;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cpx_fix_t;

  typedef enum logic [1:0] {
    BK_EMPTY,
    BK_FILLING,
    BK_FULL,
    BK_DRAINING
  } bank_st_e;

  // Reverse the low n bits of k.
  function automatic logic [31:0] bitrev(
    input logic [31:0] k,
    input int unsigned n
  );
    logic [31:0] r;
    logic [31:0] kk;
    r  = '0;
    kk = k;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        r  = {r[30:0], kk[0]};
        kk = kk >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one 2^N-entry sample bank plus its fill/drain FSM.
// Ports: clk, rst; we_i/waddr_i/wdata_i/wlast_i write side;
//   rd_i/raddr_i/rlast_i read side; rdata_o async read, st_o bank state.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic            wlast_i,
  input  logic [N-1:0]    waddr_i,
  input  logic [2*DW-1:0] wdata_i,
  input  logic            rd_i,
  input  logic            rlast_i,
  input  logic [N-1:0]    raddr_i,
  output logic [2*DW-1:0] rdata_o,
  output bank_st_e        st_o
);

  logic [2*DW-1:0] mem_q [2**N];
  bank_st_e        st_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
  assign st_o    = st_q;

  // Writes only land in EMPTY/FILLING banks and reads only in
  // FULL/DRAINING banks, so we_i and rd_i never overlap here.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= BK_EMPTY;
    end else begin
      case (st_q)
        BK_EMPTY:
          if (we_i) st_q <= wlast_i ? BK_FULL : BK_FILLING;
        BK_FILLING:
          if (we_i && wlast_i) st_q <= BK_FULL;
        BK_FULL:
          if (rd_i) st_q <= rlast_i ? BK_EMPTY : BK_DRAINING;
        BK_DRAINING:
          if (rd_i && rlast_i) st_q <= BK_EMPTY;
        default:
          st_q <= BK_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong bit-reverse to natural-order reorder buffer.
// Ports: clk, rst; in_valid/in_ready/in_re/in_im bit-reversed input stream;
//   out_valid/out_ready/out_re/out_im/out_last natural-order output stream.
// FFT_REORDER_INDEX_EN adds out_idx, the natural index of the current output.
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last
`ifdef FFT_REORDER_INDEX_EN
  ,
  output logic [N-1:0]  out_idx
`endif
);

  logic            wptr_q, rptr_q;
  logic [N-1:0]    wcnt_q, rcnt_q;
  logic            ov_q, ol_q;
  logic [DW-1:0]   ore_q, oim_q;

  bank_st_e        st    [2];
  logic [2*DW-1:0] rdata [2];
  logic            we    [2];
  logic            rd    [2];

  logic            wr_fire, wlast, rlast;
  logic            rd_avail, load;
  logic [N-1:0]    waddr;
  bank_st_e        wst, rst_st;

  assign wst      = st[wptr_q];
  assign rst_st   = st[rptr_q];
  assign in_ready = (wst != BK_FULL) && (wst != BK_DRAINING);
  assign wr_fire  = in_valid && in_ready;
  assign wlast    = (wcnt_q == '1);
  assign rlast    = (rcnt_q == '1);
  assign waddr    = N'(bitrev(32'(wcnt_q), N));

  assign rd_avail = (rst_st == BK_FULL) || (rst_st == BK_DRAINING);
  // Output register refills whenever it is empty or being consumed.
  assign load     = rd_avail && (!ov_q || out_ready);

  assign we[0] = wr_fire && !wptr_q;
  assign we[1] = wr_fire &&  wptr_q;
  assign rd[0] = load && !rptr_q;
  assign rd[1] = load &&  rptr_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .N (N),
      .DW(DW)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we_i   (we[b]),
      .wlast_i(wlast),
      .waddr_i(waddr),
      .wdata_i({in_re, in_im}),
      .rd_i   (rd[b]),
      .rlast_i(rlast),
      .raddr_i(rcnt_q),
      .rdata_o(rdata[b]),
      .st_o   (st[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      ov_q   <= 1'b0;
      ol_q   <= 1'b0;
      ore_q  <= '0;
      oim_q  <= '0;
    end else begin
      if (wr_fire) begin
        wcnt_q <= wcnt_q + 1'b1;
        if (wlast) wptr_q <= ~wptr_q;
      end
      if (load) begin
        rcnt_q         <= rcnt_q + 1'b1;
        ov_q           <= 1'b1;
        ol_q           <= rlast;
        {ore_q, oim_q} <= rdata[rptr_q];
        if (rlast) rptr_q <= ~rptr_q;
      end else if (out_ready) begin
        ov_q <= 1'b0;
        ol_q <= 1'b0;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_last  = ol_q;
  assign out_re    = ore_q;
  assign out_im    = oim_q;

`ifdef FFT_REORDER_INDEX_EN
  logic [N-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst)       idx_q <= '0;
    else if (load) idx_q <= rcnt_q;
  end

  assign out_idx = idx_q;
`endif

endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: scoreboard bench for fft_reorder_buf (N=3, DW=16).
// Golden reorder queue filled on input accept, drained on output accept.
module tb_fft_reorder_buf;
  import fft_pkg::*;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int FR = 1 << N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_re, in_im;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_re, out_im;
`ifdef FFT_REORDER_INDEX_EN
  logic [N-1:0]  out_idx;
`endif

  always #5 clk = ~clk;

  fft_reorder_buf #(
    .N (N),
    .DW(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last)
`ifdef FFT_REORDER_INDEX_EN
    ,
    .out_idx  (out_idx)
`endif
  );

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
    int            idx;
  } exp_t;

  exp_t     sb [$];
  cpx_fix_t frm [FR];
  int       fcnt = 0;
  int       vecs = 0;
  int       errs = 0;
  int       cyc = 0;
  int       stalls = 0;
  int       bubbles = 0;
  int       prev_fire = 0;
  bit       t2_on = 0;
  bit       have_prev = 0;
  bit       tog_en = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int br(input int j);
    int r = 0;
    for (int i = 0; i < N; i++) r = (r << 1) | ((j >> i) & 1);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tog_en) out_ready = ~out_ready;
  end

  // Monitor: sampled mid-cycle, describing the upcoming edge.
  initial begin
    bit            hold;
    logic [DW-1:0] hre, him;
    exp_t          e;
    hold = 0;
    hre  = '0;
    him  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        fcnt = 0;
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_v", 32'(out_valid), 1);
          chk("hold_re", 32'(out_re), 32'(hre));
          chk("hold_im", 32'(out_im), 32'(him));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("extra_out", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("out_re", 32'(out_re), 32'(e.re));
            chk("out_im", 32'(out_im), 32'(e.im));
            chk("out_last", 32'(out_last), 32'(e.last));
`ifdef FFT_REORDER_INDEX_EN
            chk("out_idx", 32'(out_idx), 32'(e.idx));
`endif
          end
          if (t2_on) begin
            if (have_prev && cyc != prev_fire + 1) bubbles++;
            have_prev = 1;
            prev_fire = cyc;
          end
        end
        hold = out_valid && !out_ready;
        hre  = out_re;
        him  = out_im;
        if (in_valid && in_ready) begin
          frm[fcnt].re = in_re;
          frm[fcnt].im = in_im;
          fcnt++;
          if (fcnt == FR) begin
            for (int j = 0; j < FR; j++) begin
              e.re   = frm[br(j)].re;
              e.im   = frm[br(j)].im;
              e.last = (j == FR - 1);
              e.idx  = j;
              sb.push_back(e);
            end
            fcnt = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                      input bit gaps);
    int w;
    if (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    w        = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      w++;
      if (w > 200) begin
        chk("in_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk({tag, "_sb"}, 32'(sb.size()), 0);
    chk({tag, "_ov"}, 32'(out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    bit a;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_ol", 32'(out_last), 0);
    chk("rst_re", 32'(out_re), 0);
    chk("rst_im", 32'(out_im), 0);
    chk("rst_ir", 32'(in_ready), 1);
    rst = 1'b0;

    // 1: ramp frame, latency of first output
    for (int i = 0; i < FR; i++) send(16'(i), 16'(-i), 0);
    in_valid = 1'b0;
    chk("t1_lat0", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("t1_lat1", 32'(out_valid), 1);
    chk("t1_first", 32'(out_re), 0);
    wait_drain("t1");

    // 2: four back-to-back frames
    stalls    = 0;
    bubbles   = 0;
    have_prev = 0;
    t2_on     = 1;
    for (int i = 0; i < 4 * FR; i++)
      send(16'($urandom), 16'($urandom), 0);
    in_valid = 1'b0;
    wait_drain("t2");
    t2_on = 0;
    chk("t2_stalls", 32'(stalls), 0);
    chk("t2_bubbles", 32'(bubbles), 0);

    // 3: output stalled, both banks fill
    out_ready = 1'b0;
    k         = 0;
    acc       = 0;
    in_valid  = 1'b1;
    in_re     = 16'(100);
    in_im     = 16'(200);
    repeat (20) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        acc++;
        k++;
        in_re = 16'(100 + k);
        in_im = 16'(200 + k);
      end
    end
    in_valid = 1'b0;
    chk("t3_acc", 32'(acc), 16);
    chk("t3_inrdy", 32'(in_ready), 0);
    chk("t3_ov", 32'(out_valid), 1);
    chk("t3_held", 32'(out_re), 100);
    out_ready = 1'b1;
    wait_drain("t3");

    // 4: toggling out_ready, random input gaps
    tog_en = 1;
    for (int i = 0; i < 3 * FR; i++)
      send(16'($urandom), 16'($urandom), 1);
    in_valid = 1'b0;
    wait_drain("t4");
    tog_en    = 0;
    out_ready = 1'b1;

    // 5: reset while draining and filling
    for (int i = 0; i < FR + 5; i++) send(16'(500 + i), 16'(600 + i), 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_ov", 32'(out_valid), 0);
    chk("t5_ol", 32'(out_last), 0);
    chk("t5_ir", 32'(in_ready), 1);
    for (int i = 0; i < FR; i++) send(16'(700 + i), 16'(800 + i), 0);
    in_valid = 1'b0;
    wait_drain("t5");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
